// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared constants for the scoreboarded register file.
//   RF_DATA_W / RF_ADDR_W / RF_NUM_RD : default data width, address width and
//                                        number of read ports
//   zero_idx(addr_w)                  : index of the hardwired-zero register
//                                        (the top register, DEPTH-1)
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int RF_DATA_W = 64;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NUM_RD = 2;

   // The zero register is always the highest index, DEPTH-1.
   function automatic int zero_idx(input int addr_w);
      return (32'sd1 << addr_w) - 32'sd1;
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_sb_if
// Bus between decode/writeback (master) and the register file (slave).
//   rd_addr  : NUM_RD packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data  : NUM_RD packed read data, port p at [p*DATA_W +: DATA_W]
//   rd_ready : per-port "no pending producer" flag
//   wr_en/wr_addr/wr_data : writeback strobe, register and data
//   iss_en/iss_addr       : issue strobe and destination register
//   flush    : clear all busy bits
//   busy_cnt : number of busy registers (registered)
//   any_busy : busy_cnt != 0
// -----------------------------------------------------------------------------
interface regfile_sb_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD
)();

   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_ready;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     iss_en;
   logic [ADDR_W-1:0]        iss_addr;
   logic                     flush;
   logic [ADDR_W:0]          busy_cnt;
   logic                     any_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      input  rd_data, rd_ready, busy_cnt, any_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
      output rd_data, rd_ready, busy_cnt, any_busy
   );

endinterface

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file.
//   i_mem       : full register storage
//   i_busy      : per-register busy bits
//   i_rd_addr   : register to read
//   i_wr_en/i_wr_addr/i_wr_data : same-cycle writeback, used for forwarding
//   o_rd_data   : read data
//   o_rd_ready  : 1 = o_rd_data is architecturally valid
// -----------------------------------------------------------------------------
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
)(
   input  logic [DATA_W-1:0]        i_mem [1 << ADDR_W],
   input  logic [(1 << ADDR_W)-1:0] i_busy,
   input  logic [ADDR_W-1:0]        i_rd_addr,
   input  logic                     i_wr_en,
   input  logic [ADDR_W-1:0]        i_wr_addr,
   input  logic [DATA_W-1:0]        i_wr_data,
   output logic [DATA_W-1:0]        o_rd_data,
   output logic                     o_rd_ready
);

   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(zero_idx(ADDR_W));

   logic w_zero;
   logic w_hit;

   // Zero register first, then writeback forwarding, then storage/busy.
   always_comb begin
      w_zero = (ZERO_REG != 0) && (i_rd_addr == ZADDR);
      w_hit  = (BYPASS != 0) && i_wr_en && (i_wr_addr == i_rd_addr);
      if (w_zero) begin
         o_rd_data  = '0;
         o_rd_ready = 1'b1;
      end else if (w_hit) begin
         o_rd_data  = i_wr_data;
         o_rd_ready = 1'b1;
      end else begin
         o_rd_data  = i_mem[i_rd_addr];
         o_rd_ready = ~i_busy[i_rd_addr];
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// Multi-read-port register file with a per-register busy scoreboard,
// writeback-to-read forwarding and an optional hardwired-zero top register.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : regfile_sb_if slave (reads, writeback, issue, flush, counters)
// -----------------------------------------------------------------------------
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
)(
   input logic          clk,
   input logic          reset_n,
   regfile_sb_if.slave  bus
);

   localparam int                DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(zero_idx(ADDR_W));

   logic [DATA_W-1:0]        r_mem [DEPTH];
   logic [DEPTH-1:0]         r_busy;
   logic [ADDR_W:0]          r_busy_cnt;

   logic                     w_wr_ok;
   logic                     w_iss_ok;
   logic                     w_inc;
   logic                     w_dec;
   logic [DEPTH-1:0]         w_busy_nxt;
   logic [ADDR_W:0]          w_cnt_nxt;
   logic [NUM_RD*DATA_W-1:0] w_rd_data;
   logic [NUM_RD-1:0]        w_rd_ready;

   // Qualify strobes: the zero register never takes data or busy state.
   always_comb begin
      w_wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.wr_addr  == ZADDR));
      w_iss_ok = bus.iss_en && !((ZERO_REG != 0) && (bus.iss_addr == ZADDR));
   end

   // Next busy vector: flush clears all; an issue is applied after the
   // writeback clear so the newer producer wins on a same-register collision.
   always_comb begin
      w_busy_nxt = r_busy;
      if (bus.flush) begin
         w_busy_nxt = '0;
      end else begin
         if (w_wr_ok) begin
            w_busy_nxt[bus.wr_addr] = 1'b0;
         end else begin
            w_busy_nxt = w_busy_nxt;
         end
         if (w_iss_ok) begin
            w_busy_nxt[bus.iss_addr] = 1'b1;
         end else begin
            w_busy_nxt = w_busy_nxt;
         end
      end
   end

   // Incremental busy counter; inc only on a non-busy target so it cannot
   // exceed DEPTH.
   always_comb begin
      w_inc = w_iss_ok && !r_busy[bus.iss_addr];
      w_dec = w_wr_ok && r_busy[bus.wr_addr] &&
              !(bus.iss_en && (bus.iss_addr == bus.wr_addr));
      if (bus.flush) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_busy_cnt + {{ADDR_W{1'b0}}, w_inc}
                                - {{ADDR_W{1'b0}}, w_dec};
      end
   end

   // Register storage; writes proceed even during a flush.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_wr_ok) begin
         r_mem[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Busy scoreboard and its population counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy     <= '0;
         r_busy_cnt <= '0;
      end else begin
         r_busy     <= w_busy_nxt;
         r_busy_cnt <= w_cnt_nxt;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd (
         .i_mem      (r_mem),
         .i_busy     (r_busy),
         .i_rd_addr  (bus.rd_addr[p*ADDR_W +: ADDR_W]),
         .i_wr_en    (bus.wr_en),
         .i_wr_addr  (bus.wr_addr),
         .i_wr_data  (bus.wr_data),
         .o_rd_data  (w_rd_data[p*DATA_W +: DATA_W]),
         .o_rd_ready (w_rd_ready[p])
      );
   end

   assign bus.rd_data  = w_rd_data;
   assign bus.rd_ready = w_rd_ready;
   assign bus.busy_cnt = r_busy_cnt;
   assign bus.any_busy = (r_busy_cnt != '0);

endmodule
